vc_flit_fifo: RTL and testbench



---
 rtl/vc_flit_fifo.sv | 170 +++++++++++++++++
 tb/tb_vc_flit_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vc_flit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vc_flit_fifo
// Purpose  : Multi-channel flit buffer. NumVC independent circular queues
//            share one storage array addressed {vc, ptr}. Each entry is a
//            flit plus its children field. Writes whose valid bit is clear
//            are dropped silently. A full channel still accepts a write when
//            the same cycle pops that channel (write-through-when-full).
//            Read data is registered (1-cycle latency) and qualified by
//            rd_valid. Overflow and underflow are sticky per channel.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            wr_en/wr_vc/wr_data - write request, target channel, entry
//            rd_en/rd_vc       - read request, source channel
//            rd_data/rd_valid  - registered popped entry and its strobe
//            empty/full/almost_full - per-channel status (bit v = channel v)
//            count             - per-channel occupancy, LgDepth+1 bits each
//            overflow/underflow - sticky per-channel error flags
// Revision : 1.0 - initial release
// ============================================================================
module vc_flit_fifo #(
   parameter int FlitWidth   = 85,
   parameter int ValidBitPos = 81,
   parameter int LgDepth     = 4,
   parameter int NumVC       = 2,
   parameter int LgNumVC     = 1,
   parameter int AfThresh    = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [LgNumVC-1:0]         wr_vc,
   input  logic [FlitWidth-1:0]       wr_data,
   input  logic                       rd_en,
   input  logic [LgNumVC-1:0]         rd_vc,
   output logic [FlitWidth-1:0]       rd_data,
   output logic                       rd_valid,
   output logic [NumVC-1:0]           empty,
   output logic [NumVC-1:0]           full,
   output logic [NumVC-1:0]           almost_full,
   output logic [NumVC*(LgDepth+1)-1:0] count,
   output logic [NumVC-1:0]           overflow,
   output logic [NumVC-1:0]           underflow
);

   localparam int c_cw    = LgDepth + 1;
   localparam int c_aw    = LgNumVC + LgDepth;
   localparam int c_depth = 1 << LgDepth;
   localparam logic [c_cw-1:0] c_depth_v = c_cw'(c_depth);
   localparam logic [c_cw-1:0] c_af_v    = c_cw'(AfThresh);

   // Shared storage; dead entries are never cleared, the pointers alone
   // define what is live.
   logic [FlitWidth-1:0] r_mem [NumVC*c_depth];

   logic [LgDepth-1:0] r_rd_ptr [NumVC];
   logic [LgDepth-1:0] r_wr_ptr [NumVC];
   logic [c_cw-1:0]    r_cnt    [NumVC];

   logic [NumVC-1:0]   w_wr_req;
   logic [NumVC-1:0]   w_rd_req;
   logic [NumVC-1:0]   w_wr_acc;
   logic [NumVC-1:0]   w_rd_acc;

   logic [LgDepth-1:0] w_wr_ptr_sel;
   logic [LgDepth-1:0] w_rd_ptr_sel;
   logic [c_aw-1:0]    w_wr_addr;
   logic [c_aw-1:0]    w_rd_addr;

   logic [FlitWidth-1:0] r_rd_data;
   logic                 r_rd_valid;
   logic [NumVC-1:0]     r_overflow;
   logic [NumVC-1:0]     r_underflow;

   // Per-channel request decode. A channel index of NumVC or above matches
   // no channel, so such requests fall away without touching any flag.
   genvar gv;
   generate
      for (gv = 0; gv < NumVC; gv++) begin : g_vc
         logic [c_cw-1:0] w_free;

         assign w_free         = c_depth_v - r_cnt[gv];
         assign empty[gv]       = (r_cnt[gv] == '0);
         assign full[gv]        = (r_cnt[gv] == c_depth_v);
         assign almost_full[gv] = (w_free <= c_af_v);
         assign count[gv*c_cw +: c_cw] = r_cnt[gv];

         assign w_wr_req[gv] = wr_en && wr_data[ValidBitPos] &&
                               (wr_vc == LgNumVC'(gv));
         assign w_rd_req[gv] = rd_en && (rd_vc == LgNumVC'(gv));
         assign w_rd_acc[gv] = w_rd_req[gv] && !empty[gv];
         // A full channel being popped this cycle frees exactly the slot
         // the write lands in.
         assign w_wr_acc[gv] = w_wr_req[gv] && (!full[gv] || w_rd_acc[gv]);

         always_ff @(posedge clk) begin
            if (rst) begin
               r_rd_ptr[gv]    <= '0;
               r_wr_ptr[gv]    <= '0;
               r_cnt[gv]       <= '0;
               r_overflow[gv]  <= 1'b0;
               r_underflow[gv] <= 1'b0;
            end else begin
               if (w_wr_acc[gv]) begin
                  r_wr_ptr[gv] <= r_wr_ptr[gv] + 1'b1;
               end
               if (w_rd_acc[gv]) begin
                  r_rd_ptr[gv] <= r_rd_ptr[gv] + 1'b1;
               end
               case ({w_wr_acc[gv], w_rd_acc[gv]})
                  2'b10:   r_cnt[gv] <= r_cnt[gv] + 1'b1;
                  2'b01:   r_cnt[gv] <= r_cnt[gv] - 1'b1;
                  default: r_cnt[gv] <= r_cnt[gv];
               endcase
               if (w_wr_req[gv] && !w_wr_acc[gv]) begin
                  r_overflow[gv] <= 1'b1;
               end
               if (w_rd_req[gv] && empty[gv]) begin
                  r_underflow[gv] <= 1'b1;
               end
            end
         end
      end
   endgenerate

   // Pointer muxes for the single write port and single read port.
   always_comb begin
      w_wr_ptr_sel = '0;
      w_rd_ptr_sel = '0;
      for (int v = 0; v < NumVC; v++) begin
         if (wr_vc == LgNumVC'(v)) begin
            w_wr_ptr_sel = r_wr_ptr[v];
         end
         if (rd_vc == LgNumVC'(v)) begin
            w_rd_ptr_sel = r_rd_ptr[v];
         end
      end
   end

   assign w_wr_addr = {wr_vc, w_wr_ptr_sel};
   assign w_rd_addr = {rd_vc, w_rd_ptr_sel};

   always_ff @(posedge clk) begin
      if (|w_wr_acc) begin
         r_mem[w_wr_addr] <= wr_data;
      end
   end

   // Read port. A read of an empty channel returns zero; with no request
   // (or an out-of-range channel) the last data is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= |w_rd_acc;
         if (|w_rd_acc) begin
            r_rd_data <= r_mem[w_rd_addr];
         end else if (|w_rd_req) begin
            r_rd_data <= '0;
         end
      end
   end

   assign rd_data   = r_rd_data;
   assign rd_valid  = r_rd_valid;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_vc_flit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_flit_fifo
// Purpose  : Self-checking bench for vc_flit_fifo using a table of directed
//            per-cycle vectors with hand-derived expected outputs, preceded
//            by a hand-written reset sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vc_flit_fifo;

   logic         clk;
   logic         rst;
   logic         wr_en;
   logic [0:0]   wr_vc;
   logic [84:0]  wr_data;
   logic         rd_en;
   logic [0:0]   rd_vc;
   logic [84:0]  rd_data;
   logic         rd_valid;
   logic [1:0]   empty;
   logic [1:0]   full;
   logic [1:0]   almost_full;
   logic [9:0]   count;
   logic [1:0]   overflow;
   logic [1:0]   underflow;

   int checks;
   int errors;

   vc_flit_fifo #(
      .FlitWidth  (85),
      .ValidBitPos(81),
      .LgDepth    (4),
      .NumVC      (2),
      .LgNumVC    (1),
      .AfThresh   (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_vc      (wr_vc),
      .wr_data    (wr_data),
      .rd_en      (rd_en),
      .rd_vc      (rd_vc),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .empty      (empty),
      .full       (full),
      .almost_full(almost_full),
      .count      (count),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        wr_en;
      logic [0:0]  wr_vc;
      logic [84:0] wr_data;
      logic        rd_en;
      logic [0:0]  rd_vc;
      logic        e_valid;
      logic [84:0] e_data;
      logic [1:0]  e_empty;
      logic [1:0]  e_full;
      logic [1:0]  e_af;
      logic [9:0]  e_count;
      logic [1:0]  e_ovf;
      logic [1:0]  e_unf;
   } vec_t;

   vec_t tbl[$];

   // Valid entry tagged with n: payload in the low bits, valid bit set,
   // children field taken from the low bits of n.
   function automatic logic [84:0] mk(input int n);
      logic [84:0] e;
      e          = '0;
      e[31:0]    = n;
      e[81]      = 1'b1;
      e[84:82]   = 3'(n);
      return e;
   endfunction

   // Status flags are derived here from the expected counts of the two
   // channels (Depth 16, almost-full when 16-count <= 2).
   task automatic add(input logic r, input logic we, input logic [0:0] wv,
                      input logic [84:0] wd, input logic re, input logic [0:0] rv,
                      input logic ev, input logic [84:0] ed,
                      input int c0, input int c1,
                      input logic [1:0] ovf, input logic [1:0] unf);
      vec_t t;
      t.rst     = r;
      t.wr_en   = we;
      t.wr_vc   = wv;
      t.wr_data = wd;
      t.rd_en   = re;
      t.rd_vc   = rv;
      t.e_valid = ev;
      t.e_data  = ed;
      t.e_empty = {c1 == 0, c0 == 0};
      t.e_full  = {c1 == 16, c0 == 16};
      t.e_af    = {(16 - c1) <= 2, (16 - c0) <= 2};
      t.e_count = {5'(c1), 5'(c0)};
      t.e_ovf   = ovf;
      t.e_unf   = unf;
      tbl.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input vec_t t);
      chk({tag, " rd_valid"},    128'(rd_valid),    128'(t.e_valid));
      chk({tag, " rd_data"},     128'(rd_data),     128'(t.e_data));
      chk({tag, " empty"},       128'(empty),       128'(t.e_empty));
      chk({tag, " full"},        128'(full),        128'(t.e_full));
      chk({tag, " almost_full"}, 128'(almost_full), 128'(t.e_af));
      chk({tag, " count"},       128'(count),       128'(t.e_count));
      chk({tag, " overflow"},    128'(overflow),    128'(t.e_ovf));
      chk({tag, " underflow"},   128'(underflow),   128'(t.e_unf));
   endtask

   initial begin
      vec_t        rs;
      logic [84:0] hold;
      logic [84:0] inv;

      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_vc   = '0;
      wr_data = '0;
      rd_en   = 1'b0;
      rd_vc   = '0;

      // ---- Fill 16 entries into VC0, then one rejected write ----
      for (int i = 1; i <= 16; i++)
         add(0, 1, 0, mk(i), 0, 0, 0, '0, i, 0, 2'b00, 2'b00);
      add(0, 1, 0, mk(99), 0, 0, 0, '0, 16, 0, 2'b01, 2'b00);
      // ---- Write-through-when-full: write 17 while popping 1 ----
      add(0, 1, 0, mk(17), 1, 0, 1, mk(1), 16, 0, 2'b01, 2'b00);
      // ---- Drain returns 2..17 ----
      for (int k = 0; k < 16; k++)
         add(0, 0, 0, '0, 1, 0, 1, mk(2 + k), 15 - k, 0, 2'b01, 2'b00);
      hold = mk(17);
      // ---- Invalid write to VC1: dropped, no overflow, data held ----
      inv     = mk(55);
      inv[81] = 1'b0;
      add(0, 1, 1, inv, 0, 0, 0, hold, 0, 0, 2'b01, 2'b00);
      // ---- Read empty VC1: zero data, underflow[1] ----
      add(0, 0, 0, '0, 1, 1, 0, '0, 0, 0, 2'b01, 2'b10);
      // ---- Interleave A->VC0, B->VC1, read VC1 then VC0 ----
      add(0, 1, 0, mk(100), 0, 0, 0, '0, 1, 0, 2'b01, 2'b10);
      add(0, 1, 1, mk(200), 0, 0, 0, '0, 1, 1, 2'b01, 2'b10);
      add(0, 0, 0, '0, 1, 1, 1, mk(200), 1, 0, 2'b01, 2'b10);
      add(0, 0, 0, '0, 1, 0, 1, mk(100), 0, 0, 2'b01, 2'b10);
      // ---- Write VC1 and read VC0 in the same cycle ----
      add(0, 1, 0, mk(110), 0, 0, 0, mk(100), 1, 0, 2'b01, 2'b10);
      add(0, 1, 1, mk(210), 1, 0, 1, mk(110), 0, 1, 2'b01, 2'b10);
      add(0, 0, 0, '0, 1, 1, 1, mk(210), 0, 0, 2'b01, 2'b10);
      // ---- Stream 40 entries through VC0 (pointers wrap) ----
      add(0, 1, 0, mk(300), 0, 0, 0, mk(210), 1, 0, 2'b01, 2'b10);
      for (int j = 1; j < 40; j++)
         add(0, 1, 0, mk(300 + j), 1, 0, 1, mk(300 + j - 1), 1, 0, 2'b01, 2'b10);
      add(0, 0, 0, '0, 1, 0, 1, mk(339), 0, 0, 2'b01, 2'b10);
      // ---- Five entries into VC0, then reset mid-operation ----
      for (int i = 1; i <= 5; i++)
         add(0, 1, 0, mk(400 + i), 0, 0, 0, mk(339), i, 0, 2'b01, 2'b10);
      add(1, 0, 0, '0, 0, 0, 0, '0, 0, 0, 2'b00, 2'b00);
      // ---- No bypass: write and read an empty VC0 together ----
      add(0, 1, 0, mk(7), 1, 0, 0, '0, 1, 0, 2'b00, 2'b01);
      add(0, 0, 0, '0, 1, 0, 1, mk(7), 0, 0, 2'b00, 2'b01);

      // ---- Initial reset, checked while still asserted ----
      repeat (2) @(posedge clk);
      #1;
      rs.e_valid = 1'b0;
      rs.e_data  = '0;
      rs.e_empty = 2'b11;
      rs.e_full  = 2'b00;
      rs.e_af    = 2'b00;
      rs.e_count = '0;
      rs.e_ovf   = 2'b00;
      rs.e_unf   = 2'b00;
      check_outputs("reset", rs);

      for (int i = 0; i < tbl.size(); i++) begin
         rst     = tbl[i].rst;
         wr_en   = tbl[i].wr_en;
         wr_vc   = tbl[i].wr_vc;
         wr_data = tbl[i].wr_data;
         rd_en   = tbl[i].rd_en;
         rd_vc   = tbl[i].rd_vc;
         @(posedge clk);
         #1;
         check_outputs($sformatf("vec%0d", i), tbl[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
